pkt_len_checker: RTL and testbench
==================================

// Module: pkt_len_checker
// PURPOSE
//  Downstream stage of the 64-bit packet translator output. Checks framing (SOP/EOP order) and
//  checks per-packet length against the SOP length tag. Converts the half-word flag and the length
//  into a per-byte keep mask. Flags errored packets and re-times the stream through a 2-entry
//  skid buffer with full ready/valid backpressure. Single clock domain.
// PARAMETERS
//  DATA_WIDTH  64    beat width in bits; fixed at 64, with 8 keep bits
//  PLEN_WIDTH  14    width of the packet length tag, in bytes
//  MAX_PLEN    9600  largest legal length; a larger tag is a length error
//  CNT_WIDTH   32    width of each statistics counter
// PORTS
//  iclk             in   1           clock
//  irst_n           in   1           asynchronous reset, active low
//  ivalid           in   1           input beat valid
//  oready           out  1           ready to upstream; beat accepted when ivalid&oready
//  isop             in   1           first beat of packet
//  ieop             in   1           last beat of packet
//  iplen            in   PLEN_WIDTH  packet byte length; sampled only on the SOP beat
//  idata            in   64          data; a half-word beat carries its data in [63:32]
//  ibad             in   1           upstream bad-packet marker
//  ihalf_word_valid in   1           only the upper 32 bits of the beat are valid
//  ovalid           out  1           output beat valid
//  iready           in   1           downstream ready
//  osop/oeop        out  1           framing, passed through
//  odata            out  64          data, passed through
//  okeep            out  8           byte enables, MSB-first (bit7 = odata[63:56])
//  oerr             out  1           on the EOP beat: length or framing error for this packet
//  obad             out  1           ibad, carried with the beat
//  ocnt_pkts/ocnt_len_err/ocnt_frame_err  out  CNT_WIDTH  statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM=IDLE; skid buffer empty; oready=0 while in reset, then 1 on the first cycle after.
//   All outputs are 0 in reset: ovalid, osop, oeop, odata, okeep, oerr, obad, counters.
//  Latency: accepted beat -> ovalid exactly 1 cycle later when the buffer is empty.
//   Output beat fields stay stable while ovalid & ~iready.
//  Ready: oready = (skid buffer occupancy < 2), registered. There is no combinational
//   iready -> oready path. No beat is lost or duplicated with full throughput on either side.
//  FSM (advances only on accepted beats):
//   IDLE
//    - isop: latch rem = iplen; clear the packet error flag.
//      Error if iplen == 0 or iplen > MAX_PLEN.
//      ieop on the same beat -> stay IDLE; otherwise -> IN_PKT.
//    - no isop: the beat is dropped (no output); frame error.
//   IN_PKT
//    - isop again: emit that beat as osop=0, oeop=1, okeep=0, oerr=1, which closes the prior packet.
//      The new packet is discarded; frame error; -> DISCARD.
//    - ieop: -> IDLE.
//   DISCARD
//    - Drop beats until ieop (inclusive), then -> IDLE. No output, no counter updates.
//  Length check: cap = ihalf_word_valid ? 4 : 8.
//   - Non-EOP beat: must have rem > cap and ihalf_word_valid == 0; otherwise packet error.
//     Then rem = rem - cap, saturating at 0.
//   - EOP beat: OK iff 1 <= rem <= cap; otherwise packet error.
//  okeep: non-EOP beat = 8'hFF.
//   EOP beat: n = min(rem, cap); okeep = top n bits set (n=0 -> 8'h00; n=8 -> 8'hFF).
//  oerr = packet error flag OR error detected on the EOP beat itself; asserted on the EOP beat only.
//  Arithmetic: rem is PLEN_WIDTH wide, unsigned, and never wraps.
//  Reset mid-packet: the partial packet is discarded; the next accepted beat must carry isop.
// CONFIGURATION
//  PKT_LEN_CHECKER_STATS_EN defined:
//   - ocnt_pkts +1 per emitted EOP.
//   - ocnt_len_err +1 per EOP with a length error.
//   - ocnt_frame_err +1 per frame-error event.
//   - All three saturate at all-ones.
//  Undefined: no counter registers; the three ports are driven constant 0.
// STRUCTURE
//  pkt_pkg: beat struct pkt_beat_t {sop, eop, bad, err, keep[7:0], data[63:0]};
//   FSM enum chk_state_t {IDLE, IN_PKT, DISCARD}; constants BEAT_BYTES=8, HALF_BYTES=4.
//  Sub-module pkt_skid_buffer: a 2-entry ready/valid buffer of pkt_beat_t, registered ready,
//   async active-low reset.
// TESTING
//  1. plen=20: beats 8,8,half-word with eop -> okeep FF,FF,F0; oerr=0; ocnt_pkts=1.
//  2. plen=16 but eop on beat 1 -> beat 1 okeep=FF, oerr=1; ocnt_len_err=1.
//  3. Beat without sop in IDLE, then sop/eop plen=3 -> first beat dropped;
//     one output beat okeep=E0, oerr=0; ocnt_frame_err=1.
//  4. sop in IN_PKT -> closing beat oeop=1, okeep=00, oerr=1; the following beats to eop are dropped.
//  5. Random iready (50%) over 1000 packets -> output matches the reference queue;
//     no loss or duplication; payload stable while stalled.
//  6. irst_n low mid-packet -> all outputs 0; post-reset sop plen=8 -> okeep=FF, oerr=0.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared types and constants for the packet length checker.
// Holds the beat record carried through the skid buffer, the framing FSM
// states and the byte-mask helper used on the last beat of a packet.
package pkt_pkg;

   localparam int BEAT_BYTES = 8;
   localparam int HALF_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE,
      IN_PKT,
      DISCARD
   } chk_state_t;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic        bad;
      logic        err;
      logic [7:0]  keep;
      logic [63:0] data;
   } pkt_beat_t;

   // Top n byte lanes enabled, MSB lane first; n=0 gives none, n=8 gives all.
   function automatic logic [7:0] keep_from_count(input logic [3:0] n);
      logic [7:0] ones;
      ones = 8'hFF;
      return ~(ones >> n);
   endfunction

endpackage

// File: rtl/pkt_skid_buffer.sv
// Two-entry ready/valid buffer for pkt_beat_t.
// Ready towards the producer is a flop that only depends on occupancy, so the
// consumer's ready never reaches the producer combinationally. Entry head_q
// always drives the output; tail_q only fills when the head is stalled.
module pkt_skid_buffer
   import pkt_pkg::*;
(
   input  logic      iclk,
   input  logic      irst_n,
   input  logic      ivalid,
   output logic      oready,
   input  pkt_beat_t idata,
   output logic      ovalid,
   input  logic      iready,
   output pkt_beat_t odata
);

   logic [1:0] count_q;
   logic [1:0] count_d;
   pkt_beat_t  head_q;
   pkt_beat_t  tail_q;
   logic       push;
   logic       pop;

   assign push   = ivalid & oready;
   assign pop    = ovalid & iready;
   assign ovalid = (count_q != 2'd0);
   assign odata  = head_q;

   // Next occupancy from this cycle's push and pop.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage, occupancy and registered ready; a push into a one-entry buffer that is also draining goes straight to the head.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         count_q <= 2'd0;
         head_q  <= '0;
         tail_q  <= '0;
         oready  <= 1'b0;
      end else begin
         count_q <= count_d;
         oready  <= (count_d != 2'd2);
         case (count_q)
            2'd0: begin
               if (push) head_q <= idata;
            end
            2'd1: begin
               if (push && pop)  head_q <= idata;
               else if (push)    tail_q <= idata;
            end
            2'd2: begin
               if (pop) head_q <= tail_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pkt_len_checker.sv
// Packet framing and length checker with a 2-entry output skid buffer.
// Every accepted beat is checked against the SOP length tag; the last beat
// gets a byte mask and an error flag. Out-of-order framing drops or closes
// packets. Statistics counters exist only when PKT_LEN_CHECKER_STATS_EN is
// defined; otherwise the counter ports are tied to zero.
module pkt_len_checker
   import pkt_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int PLEN_WIDTH = 14,
   parameter int MAX_PLEN   = 9600,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  iclk,
   input  logic                  irst_n,
   input  logic                  ivalid,
   output logic                  oready,
   input  logic                  isop,
   input  logic                  ieop,
   input  logic [PLEN_WIDTH-1:0] iplen,
   input  logic [DATA_WIDTH-1:0] idata,
   input  logic                  ibad,
   input  logic                  ihalf_word_valid,
   output logic                  ovalid,
   input  logic                  iready,
   output logic                  osop,
   output logic                  oeop,
   output logic [DATA_WIDTH-1:0] odata,
   output logic [7:0]            okeep,
   output logic                  oerr,
   output logic                  obad,
   output logic [CNT_WIDTH-1:0]  ocnt_pkts,
   output logic [CNT_WIDTH-1:0]  ocnt_len_err,
   output logic [CNT_WIDTH-1:0]  ocnt_frame_err
);

   chk_state_t            state_q;
   logic [PLEN_WIDTH-1:0] rem_q;
   logic                  pkt_err_q;

   logic                  acc;
   logic [PLEN_WIDTH-1:0] cap;
   logic [PLEN_WIDTH-1:0] rem_cur;
   logic [PLEN_WIDTH-1:0] rem_next;
   logic                  hdr_err;
   logic                  beat_err;
   logic [3:0]            keep_n;
   logic                  emit;
   pkt_beat_t             beat_d;
   pkt_beat_t             beat_q;

   assign acc = ivalid & oready;

   // Per-beat length arithmetic; on an SOP beat the remaining count starts from the tag itself.
   always_comb begin
      cap      = ihalf_word_valid ? PLEN_WIDTH'(HALF_BYTES) : PLEN_WIDTH'(BEAT_BYTES);
      rem_cur  = (state_q == IDLE) ? iplen : rem_q;
      hdr_err  = (iplen == '0) || (iplen > PLEN_WIDTH'(MAX_PLEN));
      rem_next = (rem_cur > cap) ? (rem_cur - cap) : '0;
      keep_n   = (rem_cur < cap) ? rem_cur[3:0] : cap[3:0];
      if (ieop) beat_err = (rem_cur == '0) || (rem_cur > cap);
      else      beat_err = (rem_cur <= cap) || ihalf_word_valid;
   end

   // Build the outgoing beat; an SOP seen inside a packet becomes an empty errored EOP that closes the old packet.
   always_comb begin
      emit        = 1'b0;
      beat_d      = '0;
      beat_d.data = idata;
      beat_d.bad  = ibad;
      case (state_q)
         IDLE: begin
            if (isop) begin
               emit        = 1'b1;
               beat_d.sop  = 1'b1;
               beat_d.eop  = ieop;
               beat_d.keep = ieop ? keep_from_count(keep_n) : 8'hFF;
               beat_d.err  = ieop & (hdr_err | beat_err);
            end
         end
         IN_PKT: begin
            emit = 1'b1;
            if (isop) begin
               beat_d.eop  = 1'b1;
               beat_d.keep = 8'h00;
               beat_d.err  = 1'b1;
            end else begin
               beat_d.eop  = ieop;
               beat_d.keep = ieop ? keep_from_count(keep_n) : 8'hFF;
               beat_d.err  = ieop & (pkt_err_q | beat_err);
            end
         end
         default: ;
      endcase
   end

   // Framing FSM and running length state, advanced only on accepted beats; a stray SOP that also carries EOP is a complete discarded packet, so nothing further is dropped.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state_q   <= IDLE;
         rem_q     <= '0;
         pkt_err_q <= 1'b0;
      end else if (acc) begin
         case (state_q)
            IDLE: begin
               if (isop) begin
                  rem_q     <= rem_next;
                  pkt_err_q <= hdr_err | beat_err;
                  state_q   <= ieop ? IDLE : IN_PKT;
               end
            end
            IN_PKT: begin
               if (isop) begin
                  state_q <= ieop ? IDLE : DISCARD;
               end else if (ieop) begin
                  state_q <= IDLE;
               end else begin
                  rem_q     <= rem_next;
                  pkt_err_q <= pkt_err_q | beat_err;
               end
            end
            DISCARD: begin
               if (ieop) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   pkt_skid_buffer u_skid (
      .iclk   (iclk),
      .irst_n (irst_n),
      .ivalid (ivalid & emit),
      .oready (oready),
      .idata  (beat_d),
      .ovalid (ovalid),
      .iready (iready),
      .odata  (beat_q)
   );

   assign osop  = beat_q.sop;
   assign oeop  = beat_q.eop;
   assign obad  = beat_q.bad;
   assign oerr  = beat_q.err;
   assign okeep = beat_q.keep;
   assign odata = beat_q.data;

`ifdef PKT_LEN_CHECKER_STATS_EN
   logic                 ev_pkt;
   logic                 ev_len;
   logic                 ev_frame;
   logic                 closing;
   logic [CNT_WIDTH-1:0] cnt_pkts_q;
   logic [CNT_WIDTH-1:0] cnt_len_q;
   logic [CNT_WIDTH-1:0] cnt_frame_q;

   // Statistics events for an accepted beat; the forced close of a packet is a framing event, not a length event.
   always_comb begin
      closing  = (state_q == IN_PKT) & isop;
      ev_pkt   = acc & emit & beat_d.eop;
      ev_len   = acc & emit & beat_d.eop & beat_d.err & ~closing;
      ev_frame = acc & (((state_q == IDLE) & ~isop) | closing);
   end

   // Saturating statistics counters.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         cnt_pkts_q  <= '0;
         cnt_len_q   <= '0;
         cnt_frame_q <= '0;
      end else begin
         if (ev_pkt   && !(&cnt_pkts_q))  cnt_pkts_q  <= cnt_pkts_q + 1'b1;
         if (ev_len   && !(&cnt_len_q))   cnt_len_q   <= cnt_len_q + 1'b1;
         if (ev_frame && !(&cnt_frame_q)) cnt_frame_q <= cnt_frame_q + 1'b1;
      end
   end

   assign ocnt_pkts      = cnt_pkts_q;
   assign ocnt_len_err   = cnt_len_q;
   assign ocnt_frame_err = cnt_frame_q;
`else
   assign ocnt_pkts      = '0;
   assign ocnt_len_err   = '0;
   assign ocnt_frame_err = '0;
`endif

endmodule

// File: tb/tb_pkt_len_checker.sv
// Self-checking bench for pkt_len_checker.
// A behavioural reference model runs on every accepted input beat and queues
// the beats the checker should emit; a monitor pops and compares each output
// handshake. Counter expectations follow PKT_LEN_CHECKER_STATS_EN.
module tb_pkt_len_checker;

`ifdef PKT_LEN_CHECKER_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        iclk;
   logic        irst_n;
   logic        ivalid;
   logic        oready;
   logic        isop;
   logic        ieop;
   logic [13:0] iplen;
   logic [63:0] idata;
   logic        ibad;
   logic        ihalf_word_valid;
   logic        ovalid;
   logic        iready;
   logic        osop;
   logic        oeop;
   logic [63:0] odata;
   logic [7:0]  okeep;
   logic        oerr;
   logic        obad;
   logic [31:0] ocnt_pkts;
   logic [31:0] ocnt_len_err;
   logic [31:0] ocnt_frame_err;

   int          numVectors = 0;
   int          numMiscompares = 0;
   bit          randomReady = 0;

   logic [75:0] expQ[$];
   logic [7:0]  obsKeep[$];
   logic        obsErr[$];
   logic        obsEop[$];

   int          mState = 0;
   int          mRem = 0;
   bit          mErr = 0;
   int          mPkts = 0;
   int          mLenErr = 0;
   int          mFrameErr = 0;

   logic [75:0] curBeat;
   logic [75:0] heldBeat;
   bit          held = 0;

   assign curBeat = {osop, oeop, obad, oerr, okeep, odata};

   pkt_len_checker dut (
      .iclk             (iclk),
      .irst_n           (irst_n),
      .ivalid           (ivalid),
      .oready           (oready),
      .isop             (isop),
      .ieop             (ieop),
      .iplen            (iplen),
      .idata            (idata),
      .ibad             (ibad),
      .ihalf_word_valid (ihalf_word_valid),
      .ovalid           (ovalid),
      .iready           (iready),
      .osop             (osop),
      .oeop             (oeop),
      .odata            (odata),
      .okeep            (okeep),
      .oerr             (oerr),
      .obad             (obad),
      .ocnt_pkts        (ocnt_pkts),
      .ocnt_len_err     (ocnt_len_err),
      .ocnt_frame_err   (ocnt_frame_err)
   );

   // Free-running 10-unit clock.
   initial begin
      iclk = 1'b0;
      forever #5 iclk = ~iclk;
   end

   // Downstream ready: held high for directed tests, coin-flipped each cycle in the random test.
   initial begin
      iready = 1'b1;
      forever begin
         @(posedge iclk);
         #1;
         iready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Hard stop in case something stalls forever.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      numVectors++;
      if (obs !== exp) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] keepOf(input int n);
      logic [7:0] k;
      k = 8'h00;
      for (int i = 0; i < n && i < 8; i++) k[7-i] = 1'b1;
      return k;
   endfunction

   function automatic logic [63:0] randData();
      return {$urandom(), $urandom()};
   endfunction

   // Reference model: consumes one accepted beat and queues whatever the checker must emit.
   task automatic modelBeat(input bit sop, input bit eop, input bit half, input bit bad,
                            input int plen, input logic [63:0] data);
      int cap;
      int rem;
      bit e;
      cap = half ? 4 : 8;
      case (mState)
         0: begin
            if (!sop) begin
               mFrameErr++;
            end else begin
               rem = plen;
               e   = (plen == 0) || (plen > 9600);
               if (eop) begin
                  e = e || (rem < 1) || (rem > cap);
                  expQ.push_back({1'b1, 1'b1, bad, e, keepOf(rem < cap ? rem : cap), data});
                  mPkts++;
                  if (e) mLenErr++;
               end else begin
                  if (rem <= cap || half) e = 1'b1;
                  mRem   = (rem > cap) ? rem - cap : 0;
                  mErr   = e;
                  expQ.push_back({1'b1, 1'b0, bad, 1'b0, 8'hFF, data});
                  mState = 1;
               end
            end
         end
         1: begin
            if (sop) begin
               expQ.push_back({1'b0, 1'b1, bad, 1'b1, 8'h00, data});
               mPkts++;
               mFrameErr++;
               mState = eop ? 0 : 2;
            end else begin
               rem = mRem;
               if (eop) begin
                  e = mErr || (rem < 1) || (rem > cap);
                  expQ.push_back({1'b0, 1'b1, bad, e, keepOf(rem < cap ? rem : cap), data});
                  mPkts++;
                  if (e) mLenErr++;
                  mState = 0;
               end else begin
                  if (rem <= cap || half) mErr = 1'b1;
                  mRem = (rem > cap) ? rem - cap : 0;
                  expQ.push_back({1'b0, 1'b0, bad, 1'b0, 8'hFF, data});
               end
            end
         end
         default: begin
            if (eop) mState = 0;
         end
      endcase
   endtask

   // Offer one beat until accepted (oready sampled at the negedge before the accepting edge).
   task automatic applyStimulus(input bit sop, input bit eop, input bit half, input bit bad,
                                input int plen, input logic [63:0] data);
      bit accepted;
      accepted         = 1'b0;
      ivalid           = 1'b1;
      isop             = sop;
      ieop             = eop;
      ihalf_word_valid = half;
      ibad             = bad;
      iplen            = 14'(plen);
      idata            = data;
      for (int c = 0; c < 1000 && !accepted; c++) begin
         @(negedge iclk);
         accepted = oready;
         @(posedge iclk);
         #1;
      end
      if (!accepted) checkOutput("accept_timeout", 0, 1);
      else           modelBeat(sop, eop, half, bad, plen, data);
      ivalid = 1'b0;
      isop   = 1'b0;
      ieop   = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      ivalid = 1'b0;
      repeat (n) @(posedge iclk);
      #1;
   endtask

   task automatic waitDrain(input string tag);
      for (int c = 0; c < 1000 && expQ.size() != 0; c++) @(posedge iclk);
      @(posedge iclk);
      #1;
      checkOutput(tag, expQ.size(), 0);
   endtask

   task automatic clearObs();
      obsKeep.delete();
      obsErr.delete();
      obsEop.delete();
   endtask

   function automatic logic [7:0] getKeep(input int i);
      return (obsKeep.size() > i) ? obsKeep[i] : 8'hxx;
   endfunction

   function automatic logic getLastErr();
      return (obsErr.size() > 0) ? obsErr[obsErr.size()-1] : 1'bx;
   endfunction

   // Output monitor: scoreboard pop on every handshake, and hold check while stalled.
   always @(negedge iclk) begin
      if (!irst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            checkOutput("stall_valid", ovalid, 1);
            checkOutput("stall_beat", curBeat, heldBeat);
         end
         if (ovalid && iready) begin
            if (expQ.size() == 0) checkOutput("spurious_beat", curBeat, 0);
            else                  checkOutput("beat", curBeat, expQ.pop_front());
            obsKeep.push_back(okeep);
            obsErr.push_back(oerr);
            obsEop.push_back(oeop);
         end
         held     = ovalid && !iready;
         heldBeat = curBeat;
      end
   end

   // Directed scenarios, then the randomised backpressure run, then reset mid-packet.
   initial begin
      int bPkts, bLen, bFrame;
      int plen, tag, mode, rem, idx;
      bit half, last, bad;

      irst_n = 1'b0; ivalid = 1'b0; isop = 1'b0; ieop = 1'b0;
      iplen = '0; idata = '0; ibad = 1'b0; ihalf_word_valid = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      checkOutput("rst_oready", oready, 0);
      checkOutput("rst_outs", {ovalid, osop, oeop, oerr, obad, okeep, odata}, 0);
      checkOutput("rst_cnts", {ocnt_pkts, ocnt_len_err, ocnt_frame_err}, 0);
      @(negedge iclk);
      irst_n = 1'b1;
      @(posedge iclk);
      #1;
      checkOutput("oready_after_rst", oready, 1);

      // 1: plen 20 over 8, 8, half-word
      clearObs(); bPkts = int'(ocnt_pkts);
      applyStimulus(1, 0, 0, 0, 20, randData());
      checkOutput("t1_latency", ovalid, 1);
      applyStimulus(0, 0, 0, 0, 20, randData());
      applyStimulus(0, 1, 1, 0, 20, randData());
      waitDrain("t1_drain");
      checkOutput("t1_count", obsKeep.size(), 3);
      checkOutput("t1_keep", {getKeep(0), getKeep(1), getKeep(2)}, 24'hFFFFF0);
      checkOutput("t1_err", getLastErr(), 0);
      checkOutput("t1_pkts", int'(ocnt_pkts) - bPkts, STATS);

      // 2: plen 16 ends on the first beat
      clearObs(); bLen = int'(ocnt_len_err);
      applyStimulus(1, 1, 0, 0, 16, randData());
      waitDrain("t2_drain");
      checkOutput("t2_keep", getKeep(0), 8'hFF);
      checkOutput("t2_err", getLastErr(), 1);
      checkOutput("t2_len_err", int'(ocnt_len_err) - bLen, STATS);

      // 3: stray beat in IDLE, then a 3-byte single-beat packet
      clearObs(); bFrame = int'(ocnt_frame_err);
      applyStimulus(0, 0, 0, 0, 5, randData());
      checkOutput("t3_dropped", ovalid, 0);
      applyStimulus(1, 1, 0, 0, 3, randData());
      waitDrain("t3_drain");
      checkOutput("t3_count", obsKeep.size(), 1);
      checkOutput("t3_keep", getKeep(0), 8'hE0);
      checkOutput("t3_err", getLastErr(), 0);
      checkOutput("t3_frame_err", int'(ocnt_frame_err) - bFrame, STATS);

      // 4: SOP inside a packet closes it; the rest is discarded
      clearObs(); bFrame = int'(ocnt_frame_err); bPkts = int'(ocnt_pkts);
      applyStimulus(1, 0, 0, 0, 24, randData());
      applyStimulus(1, 0, 0, 0, 24, randData());
      applyStimulus(0, 0, 0, 0, 24, randData());
      applyStimulus(0, 1, 0, 0, 24, randData());
      waitDrain("t4_drain");
      checkOutput("t4_count", obsKeep.size(), 2);
      checkOutput("t4_keep", {getKeep(0), getKeep(1)}, 16'hFF00);
      checkOutput("t4_close_eop", (obsEop.size() > 1) ? obsEop[1] : 1'bx, 1);
      checkOutput("t4_err", getLastErr(), 1);
      checkOutput("t4_frame_err", int'(ocnt_frame_err) - bFrame, STATS);
      checkOutput("t4_pkts", int'(ocnt_pkts) - bPkts, STATS);
      applyStimulus(1, 1, 0, 0, 8, randData());
      waitDrain("t4b_drain");
      checkOutput("t4_after_keep", getKeep(2), 8'hFF);
      checkOutput("t4_after_err", getLastErr(), 0);

      // 5: 1000 random packets with error injection and random downstream stalls
      randomReady = 1'b1;
      for (int p = 0; p < 1000; p++) begin
         plen = $urandom_range(1, 64);
         mode = $urandom_range(0, 11);
         bad  = 1'($urandom_range(0, 1));
         tag  = plen;
         if (mode == 0) tag = plen + $urandom_range(1, 8);
         if (mode == 1) tag = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9601, 16383);
         if (mode == 2) applyStimulus(0, 1'($urandom_range(0, 1)), 0, bad, tag, randData());
         rem  = plen;
         idx  = 0;
         last = 1'b0;
         while (!last) begin
            if (rem <= 4 && $urandom_range(0, 1) == 1) begin
               half = 1'b1; last = 1'b1;
            end else if (rem <= 8) begin
               half = 1'b0; last = 1'b1;
            end else begin
               half = (mode == 3) && ($urandom_range(0, 3) == 0);
               rem  = rem - 8;
            end
            applyStimulus(idx == 0, last, half, bad, tag, randData());
            if (!last && mode == 4 && idx == 0) applyStimulus(1, 0, 0, bad, tag, randData());
            idx++;
            if ($urandom_range(0, 4) == 0) idleCycles(1);
         end
      end
      randomReady = 1'b0;
      waitDrain("t5_drain");
      checkOutput("t5_pkts", ocnt_pkts, STATS * mPkts);
      checkOutput("t5_len_err", ocnt_len_err, STATS * mLenErr);
      checkOutput("t5_frame_err", ocnt_frame_err, STATS * mFrameErr);

      // 6: reset in the middle of a packet, then a clean 8-byte packet
      applyStimulus(1, 0, 0, 0, 24, randData());
      @(negedge iclk);
      #2;
      irst_n = 1'b0;
      #1;
      expQ.delete(); clearObs();
      mState = 0; mRem = 0; mErr = 1'b0; mPkts = 0; mLenErr = 0; mFrameErr = 0;
      checkOutput("t6_rst_outs", {oready, ovalid, osop, oeop, oerr, obad, okeep, odata}, 0);
      checkOutput("t6_rst_cnts", {ocnt_pkts, ocnt_len_err, ocnt_frame_err}, 0);
      repeat (2) @(posedge iclk);
      @(negedge iclk);
      irst_n = 1'b1;
      applyStimulus(1, 1, 0, 0, 8, randData());
      waitDrain("t6_drain");
      checkOutput("t6_count", obsKeep.size(), 1);
      checkOutput("t6_keep", getKeep(0), 8'hFF);
      checkOutput("t6_err", getLastErr(), 0);
      checkOutput("t6_pkts", ocnt_pkts, STATS);

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule
